// File: rtl/dcache_snoop_responder_if.sv
// Snoop/invalidate bus between the coherence controller, the dcache frame arrays
// and the snoop responder. The master side is the controller plus frame storage.
interface dcache_snoop_responder_if #(
  parameter int SETS = 8,
  parameter int WAYS = 2
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 3;
  localparam int WAY_W = $clog2(WAYS);

  // Supply handshake: while cctrans is high, dstore/daddr hold one word; the word
  // is accepted at the rising edge of any cycle in which dwait is low.
  logic                  ccwait;
  logic                  ccinv;
  logic [31:0]           ccsnoopaddr;
  logic                  dwait;

  logic [IDX_W-1:0]      snp_idx;
  logic [WAYS-1:0]       way_valid;
  logic [WAYS-1:0]       way_dirty;
  logic [WAYS*TAG_W-1:0] way_tag;
  logic [WAYS*64-1:0]    way_data;

  logic                  upd_en;
  logic [WAY_W-1:0]      upd_way;
  logic [IDX_W-1:0]      upd_idx;
  logic                  upd_valid;
  logic                  upd_dirty;

  logic                  cctrans;
  logic [31:0]           dstore;
  logic [31:0]           daddr;
  logic                  snp_active;

  logic [31:0]           link_addr;
  logic                  link_valid;
  logic                  link_clear;

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    output way_valid, way_dirty, way_tag, way_data,
    output link_addr, link_valid,
    input  snp_idx, upd_en, upd_way, upd_idx, upd_valid, upd_dirty,
    input  cctrans, dstore, daddr, snp_active, link_clear
  );

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    input  way_valid, way_dirty, way_tag, way_data,
    input  link_addr, link_valid,
    output snp_idx, upd_en, upd_way, upd_idx, upd_valid, upd_dirty,
    output cctrans, dstore, daddr, snp_active, link_clear
  );
endinterface

// File: rtl/dcache_snoop_responder.sv
// Cache-side MSI snoop responder: supplies Modified blocks on snoop hits, downgrades
// them to Shared, invalidates on ccinv and clears a matching LL/SC reservation.
module dcache_snoop_responder #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                          CLK,
  input  logic                          nRST,
  dcache_snoop_responder_if.slave       bus,
  output logic [2:0]                    dbg_state
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 3;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUP0  = 3'd1,
    SUP1  = 3'd2,
    HOLD  = 3'd3,
    INVAL = 3'd4
  } state_t;

  state_t state, state_n;

  logic [TAG_W-1:0] snp_tag;
  logic [IDX_W-1:0] snp_idx_w;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             hitm_any;
  logic [WAY_W-1:0] hitm_way;
  logic [31:0]      sup_word0;
  logic [31:0]      sup_word1;

  logic             hit_q;
  logic [WAY_W-1:0] way_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [28:0]      base_q;
  logic [31:0]      word1_q;
  logic [31:0]      dstore_q;
  logic [31:0]      daddr_q;
  logic             cctrans_q;

  logic             load_inv;
  logic             load_sup;
  logic             adv_word;
  logic             sup_done;
  logic             link_match;

  logic             unused_addr_bits;

  assign snp_tag   = bus.ccsnoopaddr[31 -: TAG_W];
  assign snp_idx_w = bus.ccsnoopaddr[3 +: IDX_W];
  assign unused_addr_bits = ^{bus.ccsnoopaddr[2:0], bus.link_addr[2:0]};

  // Descending scan so the lowest matching way is the last writer and wins.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    hitm_any  = 1'b0;
    hitm_way  = '0;
    sup_word0 = '0;
    sup_word1 = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (bus.way_valid[k] && (bus.way_tag[k*TAG_W +: TAG_W] == snp_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(k);
        if (bus.way_dirty[k]) begin
          hitm_any  = 1'b1;
          hitm_way  = WAY_W'(k);
          sup_word0 = bus.way_data[k*64 +: 32];
          sup_word1 = bus.way_data[k*64+32 +: 32];
        end
      end
    end
  end

  assign link_match = bus.link_valid && (bus.link_addr[31:3] == {tag_q, idx_q});

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    load_inv      = 1'b0;
    load_sup      = 1'b0;
    adv_word      = 1'b0;
    sup_done      = 1'b0;
    bus.upd_en    = 1'b0;
    bus.upd_way   = '0;
    bus.upd_idx   = '0;
    bus.upd_valid = 1'b0;
    bus.upd_dirty = 1'b0;
    bus.link_clear = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ccinv) begin
          load_inv = 1'b1;
          state_n  = INVAL;
        end else if (bus.ccwait && hitm_any) begin
          load_sup = 1'b1;
          state_n  = SUP0;
        end else if (bus.ccwait) begin
          state_n  = HOLD;
        end
      end
      SUP0: begin
        if (!bus.dwait) begin
          adv_word = 1'b1;
          state_n  = SUP1;
        end
      end
      SUP1: begin
        if (!bus.dwait) begin
          sup_done      = 1'b1;
          bus.upd_en    = 1'b1;
          bus.upd_way   = way_q;
          bus.upd_idx   = idx_q;
          bus.upd_valid = 1'b1;
          bus.upd_dirty = 1'b0;
          state_n       = IDLE;
        end
      end
      HOLD: begin
        if (bus.ccinv) begin
          load_inv = 1'b1;
          state_n  = INVAL;
        end else if (!bus.ccwait) begin
          state_n  = IDLE;
        end
      end
      INVAL: begin
        // A miss still checks the reservation: the link may name a block we lost earlier.
        bus.upd_en     = hit_q;
        bus.upd_way    = hit_q ? way_q : '0;
        bus.upd_idx    = hit_q ? idx_q : '0;
        bus.link_clear = link_match;
        state_n        = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // dstore/daddr/cctrans are registered so the controller's latched copy stays stable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q     <= 1'b0;
      way_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      base_q    <= '0;
      word1_q   <= '0;
      dstore_q  <= '0;
      daddr_q   <= '0;
      cctrans_q <= 1'b0;
    end else begin
      if (load_inv) begin
        hit_q <= hit_any;
        way_q <= hit_way;
        idx_q <= snp_idx_w;
        tag_q <= snp_tag;
      end
      if (load_sup) begin
        hit_q     <= 1'b1;
        way_q     <= hitm_way;
        idx_q     <= snp_idx_w;
        tag_q     <= snp_tag;
        base_q    <= bus.ccsnoopaddr[31:3];
        word1_q   <= sup_word1;
        dstore_q  <= sup_word0;
        daddr_q   <= {bus.ccsnoopaddr[31:3], 3'b000};
        cctrans_q <= 1'b1;
      end
      if (adv_word) begin
        dstore_q <= word1_q;
        daddr_q  <= {base_q, 3'b100};
      end
      if (sup_done) begin
        dstore_q  <= '0;
        daddr_q   <= '0;
        cctrans_q <= 1'b0;
      end
    end
  end

  assign bus.snp_idx    = snp_idx_w;
  assign bus.cctrans    = cctrans_q;
  assign bus.dstore     = dstore_q;
  assign bus.daddr      = daddr_q;
  assign bus.snp_active = (state != IDLE) || bus.ccwait || bus.ccinv;
  assign dbg_state      = state;

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Directed bench for dcache_snoop_responder: a small frame-array model answers the
// responder's lookups and absorbs its state updates.
module tb_dcache_snoop_responder;
  localparam int SETS  = 8;
  localparam int WAYS  = 2;
  localparam int TAG_W = 26;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SUP0  = 3'd1;
  localparam logic [2:0] S_SUP1  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_INVAL = 3'd4;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [2:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  logic             f_valid [SETS][WAYS];
  logic             f_dirty [SETS][WAYS];
  logic [TAG_W-1:0] f_tag   [SETS][WAYS];
  logic [63:0]      f_data  [SETS][WAYS];

  dcache_snoop_responder_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

  dcache_snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // frame arrays: combinational read, write on upd_en
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      bus.way_valid[k]                = f_valid[bus.snp_idx][k];
      bus.way_dirty[k]                = f_dirty[bus.snp_idx][k];
      bus.way_tag[k*TAG_W +: TAG_W]   = f_tag[bus.snp_idx][k];
      bus.way_data[k*64 +: 64]        = f_data[bus.snp_idx][k];
    end
  end

  always @(posedge CLK) begin
    if (nRST && bus.upd_en) begin
      f_valid[bus.upd_idx][bus.upd_way] = bus.upd_valid;
      f_dirty[bus.upd_idx][bus.upd_way] = bus.upd_dirty;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL rst_cctrans got=%0b want=0", bus.cctrans); end
    checks++; if (bus.dstore !== 32'h0) begin errors++; $display("FAIL rst_dstore got=%h want=0", bus.dstore); end
    checks++; if (bus.daddr !== 32'h0) begin errors++; $display("FAIL rst_daddr got=%h want=0", bus.daddr); end
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL rst_upd_en got=%0b want=0", bus.upd_en); end
    checks++; if (bus.link_clear !== 1'b0) begin errors++; $display("FAIL rst_link_clear got=%0b want=0", bus.link_clear); end
    checks++; if (bus.snp_active !== 1'b0) begin errors++; $display("FAIL rst_snp_active got=%0b want=0", bus.snp_active); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, S_IDLE); end
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_release_state got=%0d want=%0d", dbg_state, S_IDLE); end
    tick();
  endtask

  task automatic test_snoop_m_hit;
    f_valid[1][1] = 1'b1; f_dirty[1][1] = 1'b1; f_tag[1][1] = 26'h69;
    f_data[1][1] = {32'hCAFEF00D, 32'hDEADBEEF};
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48; bus.dwait = 1'b1;
    @(negedge CLK);
    checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL m_cctrans_c1 got=%0b want=0", bus.cctrans); end
    checks++; if (bus.snp_idx !== 3'd1) begin errors++; $display("FAIL m_snp_idx got=%0d want=1", bus.snp_idx); end
    tick();
    @(negedge CLK);
    checks++; if (bus.cctrans !== 1'b1) begin errors++; $display("FAIL m_cctrans_c2 got=%0b want=1", bus.cctrans); end
    checks++; if (bus.dstore !== 32'hDEADBEEF) begin errors++; $display("FAIL m_dstore_w0 got=%h want=deadbeef", bus.dstore); end
    checks++; if (bus.daddr !== 32'h0000_1A48) begin errors++; $display("FAIL m_daddr_w0 got=%h want=00001a48", bus.daddr); end
    tick();
    bus.ccwait = 1'b0;
    @(negedge CLK);
    checks++; if (bus.dstore !== 32'hDEADBEEF) begin errors++; $display("FAIL m_dstore_w0_hold got=%h want=deadbeef", bus.dstore); end
    checks++; if (bus.snp_active !== 1'b1) begin errors++; $display("FAIL m_snp_active got=%0b want=1", bus.snp_active); end
    tick();
    bus.dwait = 1'b0;
    @(negedge CLK);
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL m_upd_en_sup0 got=%0b want=0", bus.upd_en); end
    tick();
    bus.dwait = 1'b1;
    @(negedge CLK);
    checks++; if (bus.dstore !== 32'hCAFEF00D) begin errors++; $display("FAIL m_dstore_w1 got=%h want=cafef00d", bus.dstore); end
    checks++; if (bus.daddr !== 32'h0000_1A4C) begin errors++; $display("FAIL m_daddr_w1 got=%h want=00001a4c", bus.daddr); end
    checks++; if (bus.cctrans !== 1'b1) begin errors++; $display("FAIL m_cctrans_sup1 got=%0b want=1", bus.cctrans); end
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL m_upd_en_wait got=%0b want=0", bus.upd_en); end
    tick();
    bus.dwait = 1'b0;
    @(negedge CLK);
    checks++; if (bus.upd_en !== 1'b1) begin errors++; $display("FAIL m_upd_en got=%0b want=1", bus.upd_en); end
    checks++; if (bus.upd_way !== 1'b1) begin errors++; $display("FAIL m_upd_way got=%0d want=1", bus.upd_way); end
    checks++; if (bus.upd_idx !== 3'd1) begin errors++; $display("FAIL m_upd_idx got=%0d want=1", bus.upd_idx); end
    checks++; if (bus.upd_valid !== 1'b1) begin errors++; $display("FAIL m_upd_valid got=%0b want=1", bus.upd_valid); end
    checks++; if (bus.upd_dirty !== 1'b0) begin errors++; $display("FAIL m_upd_dirty got=%0b want=0", bus.upd_dirty); end
    tick();
    bus.dwait = 1'b1;
    @(negedge CLK);
    checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL m_cctrans_after got=%0b want=0", bus.cctrans); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL m_state_after got=%0d want=%0d", dbg_state, S_IDLE); end
    checks++; if (f_dirty[1][1] !== 1'b0 || f_valid[1][1] !== 1'b1) begin errors++; $display("FAIL m_frame_s got=v%0b d%0b want=v1 d0", f_valid[1][1], f_dirty[1][1]); end
    tick();
  endtask

  task automatic test_snoop_miss;
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL miss_cctrans c%0d got=%0b want=0", i, bus.cctrans); end
      checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL miss_upd_en c%0d got=%0b want=0", i, bus.upd_en); end
      checks++; if (bus.snp_active !== 1'b1) begin errors++; $display("FAIL miss_snp_active c%0d got=%0b want=1", i, bus.snp_active); end
      tick();
    end
    bus.ccwait = 1'b0;
    @(negedge CLK);
    checks++; if (dbg_state !== S_HOLD) begin errors++; $display("FAIL miss_state_drop got=%0d want=%0d", dbg_state, S_HOLD); end
    tick();
    @(negedge CLK);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL miss_state_idle got=%0d want=%0d", dbg_state, S_IDLE); end
    checks++; if (bus.snp_active !== 1'b0) begin errors++; $display("FAIL miss_snp_active_idle got=%0b want=0", bus.snp_active); end
    tick();
  endtask

  task automatic test_snoop_s_hit;
    for (int burst = 0; burst < 2; burst++) begin
      bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48;
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL s_cctrans b%0d c%0d got=%0b want=0", burst, i, bus.cctrans); end
        checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL s_upd_en b%0d c%0d got=%0b want=0", burst, i, bus.upd_en); end
        checks++; if (dbg_state !== ((i == 0) ? S_IDLE : S_HOLD)) begin errors++; $display("FAIL s_state b%0d c%0d got=%0d want=%0d", burst, i, dbg_state, (i == 0) ? S_IDLE : S_HOLD); end
        tick();
      end
      bus.ccwait = 1'b0;
      @(negedge CLK);
      checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL s_upd_en_gap b%0d got=%0b want=0", burst, bus.upd_en); end
      tick();
    end
  endtask

  task automatic test_hold_inval;
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48;
    tick();
    bus.ccwait = 1'b0; bus.ccinv = 1'b1;
    bus.link_addr = 32'h0000_1A4C; bus.link_valid = 1'b1;
    @(negedge CLK);
    checks++; if (dbg_state !== S_HOLD) begin errors++; $display("FAIL hi_state_hold got=%0d want=%0d", dbg_state, S_HOLD); end
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL hi_upd_en_hold got=%0b want=0", bus.upd_en); end
    tick();
    bus.ccinv = 1'b0;
    @(negedge CLK);
    checks++; if (bus.upd_en !== 1'b1) begin errors++; $display("FAIL hi_upd_en got=%0b want=1", bus.upd_en); end
    checks++; if (bus.upd_way !== 1'b1) begin errors++; $display("FAIL hi_upd_way got=%0d want=1", bus.upd_way); end
    checks++; if (bus.upd_idx !== 3'd1) begin errors++; $display("FAIL hi_upd_idx got=%0d want=1", bus.upd_idx); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL hi_upd_valid got=%0b want=0", bus.upd_valid); end
    checks++; if (bus.upd_dirty !== 1'b0) begin errors++; $display("FAIL hi_upd_dirty got=%0b want=0", bus.upd_dirty); end
    checks++; if (bus.link_clear !== 1'b1) begin errors++; $display("FAIL hi_link_clear got=%0b want=1", bus.link_clear); end
    tick();
    @(negedge CLK);
    checks++; if (f_valid[1][1] !== 1'b0) begin errors++; $display("FAIL hi_frame_inv got=%0b want=0", f_valid[1][1]); end
    checks++; if (bus.link_clear !== 1'b0) begin errors++; $display("FAIL hi_link_clear_pulse got=%0b want=0", bus.link_clear); end
    bus.link_valid = 1'b0;
    tick();
  endtask

  task automatic test_inval_miss;
    bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0000_3000;
    bus.link_addr = 32'h0000_1A48; bus.link_valid = 1'b1;
    tick();
    bus.ccinv = 1'b0;
    @(negedge CLK);
    checks++; if (dbg_state !== S_INVAL) begin errors++; $display("FAIL im_state got=%0d want=%0d", dbg_state, S_INVAL); end
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL im_upd_en got=%0b want=0", bus.upd_en); end
    checks++; if (bus.link_clear !== 1'b0) begin errors++; $display("FAIL im_link_clear got=%0b want=0", bus.link_clear); end
    tick();
    // block 0x1A48 is now invalid: miss, but the reservation still matches
    bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48;
    tick();
    bus.ccinv = 1'b0;
    @(negedge CLK);
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL im_link_upd_en got=%0b want=0", bus.upd_en); end
    checks++; if (bus.link_clear !== 1'b1) begin errors++; $display("FAIL im_link_clear_match got=%0b want=1", bus.link_clear); end
    tick();
    bus.link_valid = 1'b0;
  endtask

  task automatic test_reset_mid_supply;
    f_valid[1][0] = 1'b1; f_dirty[1][0] = 1'b1; f_tag[1][0] = 26'h69;
    f_data[1][0] = {32'h2222_2222, 32'h1111_1111};
    f_valid[1][1] = 1'b1; f_dirty[1][1] = 1'b1; f_tag[1][1] = 26'h69;
    f_data[1][1] = {32'h4444_4444, 32'h3333_3333};
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h0000_1A48; bus.dwait = 1'b1;
    tick();
    bus.ccwait = 1'b0;
    @(negedge CLK);
    checks++; if (bus.dstore !== 32'h1111_1111) begin errors++; $display("FAIL rs_lowest_way got=%h want=11111111", bus.dstore); end
    bus.dwait = 1'b0;
    tick();
    bus.dwait = 1'b1;
    @(negedge CLK);
    checks++; if (bus.dstore !== 32'h2222_2222) begin errors++; $display("FAIL rs_dstore_w1 got=%h want=22222222", bus.dstore); end
    checks++; if (dbg_state !== S_SUP1) begin errors++; $display("FAIL rs_state_sup1 got=%0d want=%0d", dbg_state, S_SUP1); end
    nRST = 1'b0;
    #1;
    checks++; if (bus.cctrans !== 1'b0) begin errors++; $display("FAIL rs_cctrans got=%0b want=0", bus.cctrans); end
    checks++; if (bus.dstore !== 32'h0) begin errors++; $display("FAIL rs_dstore got=%h want=0", bus.dstore); end
    checks++; if (bus.daddr !== 32'h0) begin errors++; $display("FAIL rs_daddr got=%h want=0", bus.daddr); end
    checks++; if (bus.snp_active !== 1'b0) begin errors++; $display("FAIL rs_snp_active got=%0b want=0", bus.snp_active); end
    checks++; if (bus.upd_en !== 1'b0) begin errors++; $display("FAIL rs_upd_en got=%0b want=0", bus.upd_en); end
    bus.dwait = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    bus.dwait = 1'b1;
    @(negedge CLK);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rs_state_idle got=%0d want=%0d", dbg_state, S_IDLE); end
    checks++; if (f_dirty[1][0] !== 1'b1 || f_valid[1][0] !== 1'b1) begin errors++; $display("FAIL rs_frame_w0 got=v%0b d%0b want=v1 d1", f_valid[1][0], f_dirty[1][0]); end
    checks++; if (f_dirty[1][1] !== 1'b1 || f_valid[1][1] !== 1'b1) begin errors++; $display("FAIL rs_frame_w1 got=v%0b d%0b want=v1 d1", f_valid[1][1], f_dirty[1][1]); end
    tick();
  endtask

  initial begin
    nRST = 1'b0;
    bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0; bus.dwait = 1'b1;
    bus.link_addr = '0; bus.link_valid = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        f_valid[s][w] = 1'b0; f_dirty[s][w] = 1'b0;
        f_tag[s][w] = '0; f_data[s][w] = '0;
      end
    end
    test_reset();
    test_snoop_m_hit();
    test_snoop_miss();
    test_snoop_s_hit();
    test_hold_inval();
    test_inval_miss();
    test_reset_mid_supply();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_responder.md
Name: dcache_snoop_responder

Overview:
- Cache-side end of the MSI snoop protocol, instantiated once inside each dcache. It answers the coherence controller's snoop (ccwait/ccsnoopaddr) and invalidate (ccinv) requests.
- On a snoop hit to a Modified block it asserts cctrans and sources both block words over dstore/daddr, paced by dwait, then downgrades the frame M->S.
- It stalls the local dcache FSM while active and clears the LL/SC link on a matching invalidation.

Parameters:
- SETS, 8, number of dcache sets; IDX_W = $clog2(SETS); TAG_W = 32 - IDX_W - 3.
- WAYS, 2, associativity; WAY_W = $clog2(WAYS).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- ccwait  in  1  snoop request / hold from the coherence controller.
- ccinv  in  1  invalidate pulse for the block at ccsnoopaddr.
- ccsnoopaddr  in  32  snooped byte address: tag [31:3+IDX_W], index [2+IDX_W:3], word [2].
- dwait  in  1  low = current supplied word accepted this cycle.
- snp_idx  out  IDX_W  set index driven to the frame arrays; always ccsnoopaddr index.
- way_valid  in  WAYS  valid bits of set snp_idx (combinational read).
- way_dirty  in  WAYS  dirty (M) bits of set snp_idx.
- way_tag  in  WAYS*TAG_W  tags of set snp_idx; way k at [k*TAG_W +: TAG_W].
- way_data  in  WAYS*64  block data; way k word0 at [k*64 +: 32], word1 at [k*64+32 +: 32].
- upd_en  out  1  one-cycle frame state write.
- upd_way  out  WAY_W  way to write.
- upd_idx  out  IDX_W  set to write.
- upd_valid  out  1  new valid bit.
- upd_dirty  out  1  new dirty bit.
- cctrans  out  1  "I hold this block Modified, supplying it."
- dstore  out  32  supplied data word.
- daddr  out  32  address of the supplied word.
- snp_active  out  1  stall request to the local dcache FSM.
- link_addr  in  32  LL reservation address.
- link_valid  in  1  LL reservation valid.
- link_clear  out  1  one-cycle pulse to clear the reservation.

Behaviour:
- Reset: state IDLE. All outputs 0. Latched way, index, tag and data registers 0. Reset asserted mid-supply aborts immediately, with no upd_en.
- Hit definition:
  - hit_k = way_valid[k] & tag match.
  - hitM = any hit_k & way_dirty[k].
  - If multiple ways hit, the lowest k wins.
- State IDLE:
  - ccinv=1: register hit, way, index and tag; go to INVAL. ccinv has priority over ccwait.
  - Else ccwait=1 and hitM: register way, index, block base {addr[31:3],3'b000}, word0 and word1; go to SUP0.
  - Else ccwait=1: go to HOLD.
- State SUP0:
  - Outputs: cctrans=1, dstore=word0, daddr=base.
  - dwait=0: go to SUP1; else stay.
- State SUP1:
  - Outputs: cctrans=1, dstore=word1, daddr=base+4.
  - dwait=0: assert upd_en with upd_valid=1, upd_dirty=0 (M->S) on the latched way/index; go to IDLE.
- State HOLD (snoop miss, or hit in S):
  - ccinv=1: register lookup as in IDLE; go to INVAL.
  - Else ccwait=0: go to IDLE.
  - Else stay.
- State INVAL:
  - If the latched hit is set: upd_en=1, upd_valid=0, upd_dirty=0.
  - link_clear=1 when link_valid and link_addr[31:3] == latched {tag, idx}.
  - Go to IDLE.
- Timing: cctrans is registered and valid the cycle after the first ccwait cycle; the controller samples it on its second snoop cycle. dstore/daddr come only from registers and are stable for the whole of SUP0/SUP1, because the controller forwards a one-cycle-latched copy.
- No upd_en during IDLE or HOLD. In states SUP0/SUP1, ccwait and ccinv are ignored.
- snp_active = (state != IDLE) | ccwait | ccinv.
- Boundaries:
  - A one-cycle ccwait gap (controller LD2) returns HOLD to IDLE; the next ccwait re-enters the lookup. This is harmless.
  - A clean S hit never asserts cctrans.
  - ccinv on a miss produces no upd_en but still performs the link check.

Test Plan:
- Snoop M hit: way1 set1 tag 0x69, dirty, data {0xDEADBEEF, 0xCAFEF00D}; ccwait 2 cycles with ccsnoopaddr=0x1A48.
  - cctrans=1 from cycle 2.
  - dstore=0xDEADBEEF, daddr=0x1A48 until first dwait=0.
  - Then 0xCAFEF00D / 0x1A4C.
  - On second dwait=0: upd_en with way1, idx1, valid1, dirty0. cctrans=0 next cycle.
- Snoop miss: ccwait high 5 cycles on 0x2000 with no valid tag -> cctrans stays 0, upd_en never asserted, snp_active=1 for all 5 cycles, IDLE after ccwait drops.
- Snoop S hit (valid, clean), ccwait 3 cycles, 1 low, 3 high -> cctrans always 0, no upd_en, state re-enters lookup after the gap.
- HOLD then ccinv: ccwait drops in the same cycle ccinv=1 for 0x1A48 (way1 S), link_addr=0x1A4C, link_valid=1 -> next cycle upd_en with way1, idx1, valid0, link_clear=1.
- ccinv miss: ccinv on 0x3000 with link_addr=0x1A48 -> no upd_en, link_clear=0.
- nRST low during SUP1 -> cctrans, dstore, daddr and snp_active all 0 immediately. After release the state is IDLE and the frame is unchanged (no upd_en).
